// File: rtl/spi_cmd_pkg.sv
// Shared opcodes, FSM states and status-byte helper for the SPI command sequencer.
package spi_cmd_pkg;

    localparam logic [7:0] OP_NOP    = 8'h00;
    localparam logic [7:0] OP_LED_WR = 8'h01;
    localparam logic [7:0] OP_RNG_RD = 8'h02;
    localparam logic [7:0] OP_CNT_RD = 8'h03;
    localparam logic [7:0] OP_STATS  = 8'h04;

    localparam logic [3:0] STATUS_HDR = 4'hA;
    localparam logic [7:0] IDLE_FILL  = 8'h00;

    typedef enum logic [2:0] {
        StIdle,
        StCmd,
        StLedWr,
        StRngRd,
        StCntRd,
        StStats,
        StDrain
    } state_e;

    // full is the RNG buffer occupancy, i.e. ~rng_ready
    function automatic logic [7:0] status_byte(input logic err, input logic full);
        return {STATUS_HDR, err, full, 2'b00};
    endfunction

endpackage

// File: rtl/spi_cmd_ctrl_if.sv
// Byte-shifter and entropy-source signals seen by the SPI command sequencer.
interface spi_cmd_ctrl_if;

    logic       spi_ce0;
    logic       rx_tgl;
    logic [7:0] rx_byte;
    logic [7:0] tx_byte;
    logic [7:0] rng_data;
    logic       rng_valid;
    logic       rng_ready;

    modport master (
        output spi_ce0, rx_tgl, rx_byte, rng_data, rng_valid,
        input  tx_byte, rng_ready
    );

    modport slave (
        input  spi_ce0, rx_tgl, rx_byte, rng_data, rng_valid,
        output tx_byte, rng_ready
    );

endinterface

// File: rtl/spi_cmd_sync.sv
// Multi-flop synchronizer with rise/fall detect on the synchronized value.
module spi_cmd_sync #(
    parameter int unsigned STAGES    = 2,
    parameter logic        RESET_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic d_i,
    output logic rise_o,
    output logic fall_o
);

    logic [STAGES-1:0] sync_q, sync_d;
    logic              prev_q, prev_d;

    always_comb begin
        sync_d = {sync_q[STAGES-2:0], d_i};
        prev_d = sync_q[STAGES-1];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q <= {STAGES{RESET_VAL}};
            prev_q <= RESET_VAL;
        end else begin
            sync_q <= sync_d;
            prev_q <= prev_d;
        end
    end

    assign rise_o = sync_q[STAGES-1] & ~prev_q;
    assign fall_o = ~sync_q[STAGES-1] & prev_q;

endmodule

// File: rtl/spi_cmd_ctrl.sv
// SPI command sequencer: LED write, RNG streaming and counter snapshot readout.
// Optional SPI_CMD_CTRL_STATS_EN adds frame/error counters readable by opcode 0x04.
module spi_cmd_ctrl
    import spi_cmd_pkg::*;
#(
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned CNT_W       = 32,
    parameter int unsigned LED_W       = 5
) (
    input  logic             clk,
    input  logic             rst,
    spi_cmd_ctrl_if.slave    bus,
    input  logic [CNT_W-1:0] cnt_in,
    output logic [LED_W-1:0] led,
    output logic             err,
    output logic             busy
);

    localparam int unsigned CntBytes = CNT_W / 8;

    logic ce_rise, ce_fall, tgl_rise, tgl_fall, byte_det;

    // Chip-enable chain resets low so a frame already in progress never looks like a new select.
    spi_cmd_sync #(
        .STAGES    (SYNC_STAGES),
        .RESET_VAL (1'b0)
    ) u_sync_ce (
        .clk    (clk),
        .rst    (rst),
        .d_i    (bus.spi_ce0),
        .rise_o (ce_rise),
        .fall_o (ce_fall)
    );

    spi_cmd_sync #(
        .STAGES    (SYNC_STAGES),
        .RESET_VAL (1'b0)
    ) u_sync_tgl (
        .clk    (clk),
        .rst    (rst),
        .d_i    (bus.rx_tgl),
        .rise_o (tgl_rise),
        .fall_o (tgl_fall)
    );

    assign byte_det = tgl_rise | tgl_fall;

    state_e           state_q, state_d, cur;
    logic [7:0]       tx_q, tx_d;
    logic [LED_W-1:0] led_q, led_d;
    logic             err_q, err_d;
    logic             busy_q, busy_d;
    logic [CNT_W-1:0] snap_q, snap_d;
    logic [2:0]       slot_q, slot_d;
    logic [7:0]       buf_q, buf_d;
    logic             full_q, full_d;
    logic             rng_slot;
`ifdef SPI_CMD_CTRL_STATS_EN
    logic [7:0]       frames_q, frames_d;
    logic [7:0]       errors_q, errors_d;
`endif

    always_comb begin
        state_d  = state_q;
        tx_d     = tx_q;
        led_d    = led_q;
        err_d    = err_q;
        busy_d   = busy_q;
        snap_d   = snap_q;
        slot_d   = slot_q;
        buf_d    = buf_q;
        full_d   = full_q;
        cur      = state_q;
        rng_slot = 1'b0;
`ifdef SPI_CMD_CTRL_STATS_EN
        frames_d = frames_q;
        errors_d = errors_q;
`endif

        // Deselect wins over a byte detected in the same cycle.
        if (ce_rise) begin
            state_d = StIdle;
            busy_d  = 1'b0;
            tx_d    = status_byte(err_q, full_q);
`ifdef SPI_CMD_CTRL_STATS_EN
            if (state_q != StIdle) begin
                if (frames_q != 8'hFF) frames_d = frames_q + 8'd1;
                if (err_q && errors_q != 8'hFF) errors_d = errors_q + 8'd1;
            end
`endif
        end else begin
            // Status reports the previous frame's error before it is cleared.
            if (ce_fall) begin
                cur     = StCmd;
                state_d = StCmd;
                busy_d  = 1'b1;
                err_d   = 1'b0;
                tx_d    = status_byte(err_q, full_q);
            end
            if (byte_det) begin
                unique case (cur)
                    StCmd: begin
                        unique case (bus.rx_byte)
                            OP_NOP: begin
                                state_d = StDrain;
                                tx_d    = IDLE_FILL;
                            end
                            OP_LED_WR: begin
                                state_d = StLedWr;
                                tx_d    = 8'(led_q);
                            end
                            OP_RNG_RD: begin
                                state_d  = StRngRd;
                                rng_slot = 1'b1;
                            end
                            OP_CNT_RD: begin
                                state_d = StCntRd;
                                tx_d    = cnt_in[CNT_W-1 -: 8];
                                snap_d  = cnt_in << 8;
                                slot_d  = 3'(CntBytes - 1);
                            end
`ifdef SPI_CMD_CTRL_STATS_EN
                            OP_STATS: begin
                                state_d = StStats;
                                tx_d    = frames_q;
                                slot_d  = 3'd1;
                            end
`endif
                            default: begin
                                state_d = StDrain;
                                err_d   = 1'b1;
                                tx_d    = IDLE_FILL;
                            end
                        endcase
                    end
                    StLedWr: begin
                        led_d   = bus.rx_byte[LED_W-1:0];
                        state_d = StDrain;
                        tx_d    = IDLE_FILL;
                    end
                    StRngRd: rng_slot = 1'b1;
                    StCntRd: begin
                        if (slot_q != 3'd0) begin
                            tx_d   = snap_q[CNT_W-1 -: 8];
                            snap_d = snap_q << 8;
                            slot_d = slot_q - 3'd1;
                        end else begin
                            state_d = StDrain;
                            tx_d    = IDLE_FILL;
                        end
                    end
`ifdef SPI_CMD_CTRL_STATS_EN
                    StStats: begin
                        if (slot_q != 3'd0) begin
                            tx_d   = errors_q;
                            slot_d = slot_q - 3'd1;
                        end else begin
                            state_d = StDrain;
                            tx_d    = IDLE_FILL;
                        end
                    end
`endif
                    default: ;
                endcase
            end
        end

        if (rng_slot) begin
            if (full_q) begin
                tx_d = buf_q;
            end else begin
                tx_d  = IDLE_FILL;
                err_d = 1'b1;
            end
        end

        // Fill only when empty, so a same-cycle consume always sees the old byte.
        if (bus.rng_valid && !full_q) begin
            buf_d  = bus.rng_data;
            full_d = 1'b1;
        end else if (rng_slot) begin
            full_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= StIdle;
            tx_q     <= status_byte(1'b0, 1'b0);
            led_q    <= '0;
            err_q    <= 1'b0;
            busy_q   <= 1'b0;
            snap_q   <= '0;
            slot_q   <= 3'd0;
            buf_q    <= 8'h00;
            full_q   <= 1'b0;
`ifdef SPI_CMD_CTRL_STATS_EN
            frames_q <= 8'h00;
            errors_q <= 8'h00;
`endif
        end else begin
            state_q  <= state_d;
            tx_q     <= tx_d;
            led_q    <= led_d;
            err_q    <= err_d;
            busy_q   <= busy_d;
            snap_q   <= snap_d;
            slot_q   <= slot_d;
            buf_q    <= buf_d;
            full_q   <= full_d;
`ifdef SPI_CMD_CTRL_STATS_EN
            frames_q <= frames_d;
            errors_q <= errors_d;
`endif
        end
    end

    assign bus.tx_byte   = tx_q;
    assign bus.rng_ready = ~full_q;
    assign led           = led_q;
    assign err           = err_q;
    assign busy          = busy_q;

endmodule

// File: tb/tb_spi_cmd_ctrl.sv
// Directed bench for spi_cmd_ctrl: vector table plus hand-written multi-cycle sequences.
module tb_spi_cmd_ctrl;

    localparam int KSel   = 0;
    localparam int KDesel = 1;
    localparam int KByte  = 2;

    typedef struct {
        int         kind;
        logic [7:0] data;
        logic [7:0] exp_tx;
        logic [4:0] exp_led;
        logic       exp_err;
        logic       exp_busy;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] cnt_in;
    logic [4:0]  led;
    logic        err;
    logic        busy;
    int          checks = 0;
    int          errors = 0;
    vec_t        vecs[25];

    spi_cmd_ctrl_if bus ();

    spi_cmd_ctrl #(
        .SYNC_STAGES (2),
        .CNT_W       (32),
        .LED_W       (5)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .bus    (bus),
        .cnt_in (cnt_in),
        .led    (led),
        .err    (err),
        .busy   (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic sel();
        bus.spi_ce0 = 1'b0;
        cycles(8);
    endtask

    task automatic desel();
        bus.spi_ce0 = 1'b1;
        cycles(8);
    endtask

    task automatic send(input logic [7:0] b);
        bus.rx_byte = b;
        bus.rx_tgl  = ~bus.rx_tgl;
        cycles(8);
    endtask

    task automatic pulse_reset();
        rst = 1'b1;
        cycles(3);
        check("rst tx", 32'(bus.tx_byte), 32'hA0);
        check("rst led", 32'(led), 32'h00);
        check("rst err", 32'(err), 32'h0);
        check("rst busy", 32'(busy), 32'h0);
        check("rst rng_ready", 32'(bus.rng_ready), 32'h1);
        rst = 1'b0;
        cycles(8);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
        $fatal(1);
    end

    initial begin
        vecs[0]  = '{KSel,   8'h00, 8'hA4, 5'h00, 1'b0, 1'b1};
        vecs[1]  = '{KByte,  8'h01, 8'h00, 5'h00, 1'b0, 1'b1};
        vecs[2]  = '{KByte,  8'h15, 8'h00, 5'h15, 1'b0, 1'b1};
        vecs[3]  = '{KByte,  8'hAA, 8'h00, 5'h15, 1'b0, 1'b1};
        vecs[4]  = '{KDesel, 8'h00, 8'hA4, 5'h15, 1'b0, 1'b0};
        vecs[5]  = '{KByte,  8'h55, 8'hA4, 5'h15, 1'b0, 1'b0};
        vecs[6]  = '{KSel,   8'h00, 8'hA4, 5'h15, 1'b0, 1'b1};
        vecs[7]  = '{KByte,  8'h01, 8'h15, 5'h15, 1'b0, 1'b1};
        vecs[8]  = '{KByte,  8'hE3, 8'h00, 5'h03, 1'b0, 1'b1};
        vecs[9]  = '{KDesel, 8'h00, 8'hA4, 5'h03, 1'b0, 1'b0};
        vecs[10] = '{KSel,   8'h00, 8'hA4, 5'h03, 1'b0, 1'b1};
        vecs[11] = '{KByte,  8'h7F, 8'h00, 5'h03, 1'b1, 1'b1};
        vecs[12] = '{KByte,  8'h02, 8'h00, 5'h03, 1'b1, 1'b1};
        vecs[13] = '{KDesel, 8'h00, 8'hAC, 5'h03, 1'b1, 1'b0};
        vecs[14] = '{KSel,   8'h00, 8'hAC, 5'h03, 1'b0, 1'b1};
        vecs[15] = '{KByte,  8'h00, 8'h00, 5'h03, 1'b0, 1'b1};
        vecs[16] = '{KByte,  8'h01, 8'h00, 5'h03, 1'b0, 1'b1};
        vecs[17] = '{KDesel, 8'h00, 8'hA4, 5'h03, 1'b0, 1'b0};
        vecs[18] = '{KSel,   8'h00, 8'hA4, 5'h03, 1'b0, 1'b1};
        vecs[19] = '{KByte,  8'h03, 8'h12, 5'h03, 1'b0, 1'b1};
        vecs[20] = '{KByte,  8'h00, 8'h34, 5'h03, 1'b0, 1'b1};
        vecs[21] = '{KByte,  8'h00, 8'h56, 5'h03, 1'b0, 1'b1};
        vecs[22] = '{KByte,  8'h00, 8'h78, 5'h03, 1'b0, 1'b1};
        vecs[23] = '{KByte,  8'h00, 8'h00, 5'h03, 1'b0, 1'b1};
        vecs[24] = '{KDesel, 8'h00, 8'hA4, 5'h03, 1'b0, 1'b0};

        rst           = 1'b1;
        cnt_in        = 32'h1234_5678;
        bus.spi_ce0   = 1'b1;
        bus.rx_tgl    = 1'b0;
        bus.rx_byte   = 8'h00;
        bus.rng_data  = 8'h3C;
        bus.rng_valid = 1'b1;
        pulse_reset();

        for (int i = 0; i < 25; i++) begin
            unique case (vecs[i].kind)
                KSel:    sel();
                KDesel:  desel();
                default: send(vecs[i].data);
            endcase
            check($sformatf("vec%0d tx", i), 32'(bus.tx_byte), 32'(vecs[i].exp_tx));
            check($sformatf("vec%0d led", i), 32'(led), 32'(vecs[i].exp_led));
            check($sformatf("vec%0d err", i), 32'(err), 32'(vecs[i].exp_err));
            check($sformatf("vec%0d busy", i), 32'(busy), 32'(vecs[i].exp_busy));
        end

        // Snapshot is frozen at decode.
        sel();
        cnt_in = 32'hDEAD_BEEF;
        send(8'h03);
        check("snap b0", 32'(bus.tx_byte), 32'hDE);
        cnt_in = 32'h0102_0304;
        send(8'h00);
        check("snap b1", 32'(bus.tx_byte), 32'hAD);
        send(8'h00);
        check("snap b2", 32'(bus.tx_byte), 32'hBE);
        send(8'h00);
        check("snap b3", 32'(bus.tx_byte), 32'hEF);
        send(8'h00);
        check("snap drain", 32'(bus.tx_byte), 32'h00);
        desel();

        // RNG streaming with underrun.
        bus.rng_data = 8'hC3;
        sel();
        send(8'h02);
        check("rng b0", 32'(bus.tx_byte), 32'h3C);
        check("rng refill", 32'(bus.rng_ready), 32'h0);
        bus.rng_valid = 1'b0;
        send(8'h00);
        check("rng b1", 32'(bus.tx_byte), 32'hC3);
        check("rng b1 err", 32'(err), 32'h0);
        check("rng empty", 32'(bus.rng_ready), 32'h1);
        send(8'h00);
        check("rng under tx", 32'(bus.tx_byte), 32'h00);
        check("rng under err", 32'(err), 32'h1);
        send(8'h00);
        check("rng under2 tx", 32'(bus.tx_byte), 32'h00);
        desel();
        check("rng desel status", 32'(bus.tx_byte), 32'hA8);
        bus.rng_data  = 8'h77;
        bus.rng_valid = 1'b1;
        cycles(4);
        sel();
        check("next status", 32'(bus.tx_byte), 32'hAC);
        check("next err clr", 32'(err), 32'h0);
        desel();

        // Select and first byte detected together: byte is the command.
        bus.spi_ce0 = 1'b0;
        send(8'h01);
        check("sel+byte tx", 32'(bus.tx_byte), 32'h03);
        check("sel+byte busy", 32'(busy), 32'h1);
        send(8'h1F);
        check("sel+byte led", 32'(led), 32'h1F);
        desel();

        // Deselect and byte detected together: byte is dropped.
        sel();
        send(8'h01);
        check("led readback", 32'(bus.tx_byte), 32'h1F);
        bus.spi_ce0 = 1'b1;
        send(8'h00);
        check("desel+byte led", 32'(led), 32'h1F);
        check("desel+byte tx", 32'(bus.tx_byte), 32'hA4);
        check("desel+byte busy", 32'(busy), 32'h0);

        // Reset mid-frame: rest of the frame is ignored.
        sel();
        send(8'h03);
        check("pre-rst tx", 32'(bus.tx_byte), 32'h01);
        pulse_reset();
        send(8'h01);
        send(8'h1F);
        check("post-rst led", 32'(led), 32'h00);
        check("post-rst busy", 32'(busy), 32'h0);
        check("post-rst err", 32'(err), 32'h0);
        desel();
        check("post-rst desel", 32'(bus.tx_byte), 32'hA4);
        sel();
        check("post-rst sel busy", 32'(busy), 32'h1);
        send(8'h01);
        send(8'h09);
        check("post-rst led wr", 32'(led), 32'h09);
        desel();

        // Frame/error statistics (or illegal opcode when not built in).
        pulse_reset();
        sel();
        send(8'h00);
        desel();
        sel();
        send(8'h7F);
        desel();
        sel();
        send(8'h01);
        send(8'h00);
        desel();
        sel();
        send(8'h04);
`ifdef SPI_CMD_CTRL_STATS_EN
        check("stats frames", 32'(bus.tx_byte), 32'h03);
        check("stats err", 32'(err), 32'h0);
        send(8'h00);
        check("stats errors", 32'(bus.tx_byte), 32'h01);
        send(8'h00);
        check("stats drain", 32'(bus.tx_byte), 32'h00);
`else
        check("op04 tx", 32'(bus.tx_byte), 32'h00);
        check("op04 err", 32'(err), 32'h1);
`endif
        desel();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
